// File: rtl/stopwatch_disp_scan.sv
// Display scanner for a six-digit stopwatch on a multiplexed common-anode 7-segment display.
// It takes a coherent snapshot of the BCD digits, supports a lap freeze, and blanks between digits.
`timescale 1ns/1ps
module stopwatch_disp_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 4,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] MSH,
    input  logic [3:0] MSL,
    input  logic [3:0] SH,
    input  logic [3:0] SL,
    input  logic [3:0] MH,
    input  logic [3:0] ML,
    input  logic       LAP,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [5:0] AN,
    output logic       HOLD
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);

    logic [23:0]   s1_q, s1_d, s2_q, s2_d, snap_q, snap_d;
    logic          lap_q, lap_d, hold_q, hold_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    an_q, an_d;
    logic [3:0]    digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        s1_d   = {MH, ML, SH, SL, MSH, MSL};
        s2_d   = s1_q;
        snap_d = snap_q;
        // Load only when two consecutive samples agree, so a mid-carry value is never shown.
        if ((s1_q == s2_q) && !hold_q)
            snap_d = s2_q;
        lap_d  = LAP;
        hold_d = hold_q ^ (LAP & ~lap_q);

        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        case (idx_q)
            3'd0:    digit = snap_q[3:0];
            3'd1:    digit = snap_q[7:4];
            3'd2:    digit = snap_q[11:8];
            3'd3:    digit = snap_q[15:12];
            3'd4:    digit = snap_q[19:16];
            3'd5:    digit = snap_q[23:20];
            default: digit = 4'd0;
        endcase

        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = 6'h3F;
        if (pre_q >= PRE_BLANK) begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = seg_decode(digit);
            // Leading minutes-tens zero is dark, but its anode still fires to keep brightness uniform.
            if (LZ_BLANK && (idx_q == 3'd5) && (digit == 4'd0))
                seg_d = 7'h7F;
            dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            s1_q   <= '0;
            s2_q   <= '0;
            snap_q <= '0;
            lap_q  <= 1'b0;
            hold_q <= 1'b0;
            pre_q  <= '0;
            idx_q  <= 3'd0;
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
            an_q   <= 6'h3F;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            snap_q <= snap_d;
            lap_q  <= lap_d;
            hold_q <= hold_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    assign SEG  = seg_q;
    assign DP   = dp_q;
    assign AN   = an_q;
    assign HOLD = hold_q;

endmodule

// File: tb/tb_stopwatch_disp_scan.sv
// Randomized bench for stopwatch_disp_scan: a cycle-level behavioural model is compared every cycle,
// plus literal display checks for the scenarios of interest.
`timescale 1ns/1ps
module tb_stopwatch_disp_scan;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] MSH = 4'd0, MSL = 4'd0, SH = 4'd0, SL = 4'd0, MH = 4'd0, ML = 4'd0;
    logic       LAP = 1'b0;
    logic [6:0] SEG;
    logic       DP;
    logic [5:0] AN;
    logic       HOLD;

    int checks = 0;
    int failures = 0;

    stopwatch_disp_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1'b1)) dut (
        .CLK(CLK), .CLR(CLR), .MSH(MSH), .MSL(MSL), .SH(SH), .SL(SL), .MH(MH), .ML(ML),
        .LAP(LAP), .SEG(SEG), .DP(DP), .AN(AN), .HOLD(HOLD)
    );

    always #5 CLK = ~CLK;

    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: the display is a function of time since reset and the history of inputs.
    int          k;
    logic [23:0] hist [$];
    logic [23:0] m_snap;
    logic        m_hold, lap_prev;
    logic [6:0]  e_seg;
    logic        e_dp, e_hold;
    logic [5:0]  e_an;

    always @(posedge CLK) begin
        if (!CLR) begin
            k = 0;
            hist = {24'd0, 24'd0};
            m_snap = '0; m_hold = 1'b0; lap_prev = 1'b0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 6'h3F; e_hold = 1'b0;
        end else begin
            int pre, idx;
            logic [3:0] dg;
            pre = k % SD;
            idx = (k / SD) % 6;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 6'h3F;
            if (pre >= BC) begin
                e_an = 6'h3F & ~(6'(1) << idx);
                dg = 4'((m_snap >> (4 * idx)) & 24'hF);
                e_seg = (idx == 5 && dg == 0) ? 7'h7F : seg_tab[dg];
                e_dp = !(idx == 2 || idx == 4);
            end
            // hist[$] is the input seen one edge ago, hist[$-1] two edges ago.
            if (hist[$] == hist[$-1] && !m_hold) m_snap = hist[$];
            hist.push_back({MH, ML, SH, SL, MSH, MSL});
            void'(hist.pop_front());
            if (LAP && !lap_prev) m_hold = !m_hold;
            lap_prev = LAP;
            e_hold = m_hold;
            k++;
        end
        #1;
        check("seg", 32'(SEG), 32'(e_seg));
        check("dp", 32'(DP), 32'(e_dp));
        check("an", 32'(AN), 32'(e_an));
        check("hold", 32'(HOLD), 32'(e_hold));
    end

    task automatic set_digits(input logic [23:0] v);
        {MH, ML, SH, SL, MSH, MSL} = v;
    endtask

    task automatic wait_an(input logic [5:0] target, input string name);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            if (AN == target) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s timeout waiting for AN=%0h last=%0h", name, target, AN);
        end
    endtask

    task automatic lap_pulse();
        @(negedge CLK); LAP = 1'b1;
        @(negedge CLK); LAP = 1'b0;
    endtask

    initial begin
        set_digits(24'h595999);
        repeat (3) @(negedge CLK);
        CLR = 1'b1;

        wait_an(6'h3E, "slot0_wait");
        @(negedge CLK);
        check("slot0_seg_9", 32'(SEG), 32'h10);
        wait_an(6'h2F, "slot4_wait");
        @(negedge CLK);
        check("slot4_seg_9", 32'(SEG), 32'h10);
        check("slot4_dp", 32'(DP), 32'h0);
        wait_an(6'h1F, "slot5_wait");
        @(negedge CLK);
        check("slot5_seg_5", 32'(SEG), 32'h12);

        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 2) == 0) set_digits(24'($urandom));
            LAP = ($urandom_range(0, 15) == 0);
        end
        @(negedge CLK); LAP = 1'b0;
        @(negedge CLK);
        if (m_hold) lap_pulse();

        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            set_digits((i % 2) ? 24'h123457 : 24'h123456);
        end
        set_digits(24'h123457);
        repeat (4) @(negedge CLK);
        wait_an(6'h3E, "toggle_slot0_wait");
        @(negedge CLK);
        check("toggle_settled_7", 32'(SEG), 32'h78);

        set_digits(24'h004217);
        repeat (5) @(negedge CLK);
        lap_pulse();
        set_digits(24'h005000);
        repeat (5) @(negedge CLK);
        check("lap_hold_on", 32'(HOLD), 32'h1);
        wait_an(6'h3D, "lap_slot1_wait");
        @(negedge CLK);
        check("lap_frozen_msh_1", 32'(SEG), 32'h79);
        wait_an(6'h37, "lap_slot3_wait");
        @(negedge CLK);
        check("lap_frozen_sh_4", 32'(SEG), 32'h19);
        wait_an(6'h1F, "lap_slot5_wait");
        @(negedge CLK);
        check("lap_mh_blank", 32'(SEG), 32'h7F);
        lap_pulse();
        repeat (5) @(negedge CLK);
        check("lap_hold_off", 32'(HOLD), 32'h0);
        wait_an(6'h37, "rel_slot3_wait");
        @(negedge CLK);
        check("rel_sh_5", 32'(SEG), 32'h12);
        wait_an(6'h1F, "rel_slot5_wait");
        @(negedge CLK);
        check("rel_mh_blank", 32'(SEG), 32'h7F);

        set_digits(24'h010C00);
        repeat (4) @(negedge CLK);
        wait_an(6'h3B, "dash_wait");
        @(negedge CLK);
        check("dash_seg", 32'(SEG), 32'h3F);
        check("dash_dp", 32'(DP), 32'h0);

        @(negedge CLK);
        #2 CLR = 1'b0;
        #1;
        check("async_an", 32'(AN), 32'h3F);
        check("async_seg", 32'(SEG), 32'h7F);
        check("async_dp", 32'(DP), 32'h1);
        check("async_hold", 32'(HOLD), 32'h0);
        repeat (2) @(negedge CLK);
        CLR = 1'b1;
        begin
            bit found = 0;
            for (int i = 0; i < 50 && !found; i++) begin
                @(negedge CLK);
                if (AN != 6'h3F) found = 1;
            end
            check("first_slot_after_reset", 32'(AN), 32'h3E);
        end

        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) set_digits(24'($urandom));
            LAP = ($urandom_range(0, 9) == 0);
        end
        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
